// File: rtl/efuse_pkg.sv
// Shared definitions for the eFuse read/program datapath: state encoding,
// default timing and mode codes.
package efuse_pkg;

    localparam int unsigned EFUSE_NBITS = 32;

    localparam int unsigned DEF_TCKHP = 4;
    localparam int unsigned DEF_TCSS  = 2;
    localparam int unsigned DEF_TCKLP = 4;
    localparam int unsigned DEF_TCSH  = 2;

    localparam logic [1:0] MODE_PROG = 2'b01;
    localparam logic [1:0] MODE_READ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } efuse_state_e;

    // A programmed high period of zero still has to produce a visible pulse.
    function automatic logic [3:0] eff_tckhp(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

endpackage

// File: rtl/efuse_shift_in.sv
// Capture register for the serial fuse stream; each sampled bit lands at the
// position given by bit_idx, so bit 0 is the first bit clocked out.
module efuse_shift_in
    import efuse_pkg::*;
#(
    parameter int unsigned NBITS = EFUSE_NBITS,
    parameter int unsigned IW    = (NBITS > 1) ? $clog2(NBITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [IW-1:0]    bit_idx,
    input  logic             din,
    output logic [NBITS-1:0] word_o
);

    logic [NBITS-1:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else if (clr) begin
            word_q <= '0;
        end else if (sample_en) begin
            word_q[bit_idx] <= din;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/efuse_reader.sv
// eFuse read controller: holds CSB low, issues NBITS SCLK pulses, captures DOUT
// at the end of each high phase and publishes the word with a valid flag.
module efuse_reader
    import efuse_pkg::*;
#(
    parameter int unsigned NBITS = EFUSE_NBITS,
    parameter int unsigned TCSS  = DEF_TCSS,
    parameter int unsigned TCKLP = DEF_TCKLP,
    parameter int unsigned TCSH  = DEF_TCSH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       TCKHP,
    input  logic             DOUT,
    output logic             CSB,
    output logic             PGM,
    output logic             SCLK,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] data,
    output logic             valid
);

    localparam int unsigned BCW = $clog2(NBITS + 1);
    localparam int unsigned IW  = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [3:0]     TCSS_LAST  = 4'(TCSS - 1);
    localparam logic [3:0]     TCKLP_LAST = 4'(TCKLP - 1);
    localparam logic [3:0]     TCSH_LAST  = 4'(TCSH - 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(NBITS - 1);

    efuse_state_e     state_q, state_d;
    logic [3:0]       ph_q, ph_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]       tckhp_q, tckhp_d;
    logic             csb_q, csb_d;
    logic             sclk_q, sclk_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [NBITS-1:0] data_q, data_d;

    logic             shift_clr;
    logic             shift_en;
    logic [NBITS-1:0] shift_word;

    efuse_shift_in #(
        .NBITS (NBITS),
        .IW    (IW)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clr       (shift_clr),
        .sample_en (shift_en),
        .bit_idx   (bit_cnt_q[IW-1:0]),
        .din       (DOUT),
        .word_o    (shift_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            bit_cnt_q <= '0;
            tckhp_q   <= '0;
            csb_q     <= 1'b1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_cnt_q <= bit_cnt_d;
            tckhp_q   <= tckhp_d;
            csb_q     <= csb_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
        end
    end

    // Next state; pin outputs are decoded from state_d so they register in step with the state.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_cnt_d = bit_cnt_q;
        tckhp_d   = tckhp_q;
        valid_d   = valid_q;
        data_d    = data_q;
        shift_clr = 1'b0;
        shift_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SETUP;
                    ph_d      = '0;
                    bit_cnt_d = '0;
                    tckhp_d   = eff_tckhp(TCKHP);
                    valid_d   = 1'b0;
                    shift_clr = 1'b1;
                end
            end
            S_SETUP: begin
                if (ph_q == TCSS_LAST) begin
                    state_d = S_HIGH;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            S_HIGH: begin
                if (ph_q == tckhp_q - 4'd1) begin
                    shift_en = 1'b1;
                    state_d  = S_LOW;
                    ph_d     = '0;
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            S_LOW: begin
                if (ph_q == TCKLP_LAST) begin
                    ph_d      = '0;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    state_d   = (bit_cnt_q == BIT_LAST) ? S_HOLD : S_HIGH;
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (ph_q == TCSH_LAST) begin
                    state_d = S_DONE;
                    ph_d    = '0;
                    data_d  = shift_word;
                    valid_d = 1'b1;
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ph_d    = '0;
            end
        endcase

        csb_d  = (state_d == S_IDLE) || (state_d == S_DONE);
        sclk_d = (state_d == S_HIGH);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign CSB   = csb_q;
    assign PGM   = 1'b0;
    assign SCLK  = sclk_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: tb/tb_efuse_reader.sv
// Self-checking bench for efuse_reader: an eFuse macro model drives DOUT, and a
// timeline model predicts every pin from the start cycle of each accepted read.
module tb_efuse_reader;

    localparam int NB      = 32;
    localparam int TCSS_P  = 2;
    localparam int TCKLP_P = 4;
    localparam int TCSH_P  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    TCKHP;
    logic          DOUT;
    logic          CSB, PGM, SCLK, busy, done, valid;
    logic [NB-1:0] data;

    efuse_reader #(
        .NBITS (NB),
        .TCSS  (TCSS_P),
        .TCKLP (TCKLP_P),
        .TCSH  (TCSH_P)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .TCKHP (TCKHP),
        .DOUT  (DOUT),
        .CSB   (CSB),
        .PGM   (PGM),
        .SCLK  (SCLK),
        .busy  (busy),
        .done  (done),
        .data  (data),
        .valid (valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // eFuse macro: presents fuse bit k on the k-th SCLK rise after CSB falls,
    // and scrambles DOUT while SCLK is low so late/early sampling shows up.
    logic [NB-1:0] fuse;
    int            fidx = 0;

    always @(negedge CSB) fidx = 0;
    always @(posedge SCLK) begin
        DOUT = (fidx < NB) ? fuse[fidx] : 1'($urandom);
        fidx = fidx + 1;
    end
    always @(negedge SCLK) DOUT = 1'($urandom);

    // Timeline model: a read accepted in cycle c0 owns cycles c0+1 .. c0+T.
    bit            m_active = 1'b0;
    int            m_c0 = 0, m_h = 1, m_T = 0;
    logic [NB-1:0] m_word = '0, m_data = '0;
    logic          m_valid = 1'b0;

    function automatic int eff_h(input logic [3:0] v);
        return (v == 4'd0) ? 1 : int'(v);
    endfunction

    function automatic int read_len(input int h);
        return 1 + TCSS_P + NB * (h + TCKLP_P) + TCSH_P;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
        end else if (start && (!m_active || (cyc - m_c0) > m_T)) begin
            m_active <= 1'b1;
            m_c0     <= cyc;
            m_h      <= eff_h(TCKHP);
            m_T      <= read_len(eff_h(TCKHP));
            m_word   <= fuse;
            m_valid  <= 1'b0;
        end else if (m_active && (cyc + 1 - m_c0) == m_T) begin
            m_valid <= 1'b1;
            m_data  <= m_word;
        end
    end

    int  p_low = 0, p_since = 0;
    bit  p_seen = 1'b0;
    logic p_sclk = 1'b0, p_csb = 1'b1;

    // Per-cycle compare against the model plus the CSB/SCLK protocol rules.
    always @(negedge clk) begin : cmp
        int   rel, r;
        logic e_csb, e_sclk, e_busy, e_done;
        if (chk_en) begin
            e_csb = 1'b1; e_sclk = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            if (m_active) begin
                rel = cyc - m_c0;
                e_csb  = !(rel >= 1 && rel < m_T);
                e_busy = (rel >= 1 && rel <= m_T);
                e_done = (rel == m_T);
                r = rel - 1 - TCSS_P;
                e_sclk = (r >= 0 && r < NB * (m_h + TCKLP_P) && (r % (m_h + TCKLP_P)) < m_h);
            end
            check1("CSB", CSB, e_csb);
            check1("SCLK", SCLK, e_sclk);
            check1("busy", busy, e_busy);
            check1("done", done, e_done);
            check1("PGM", PGM, 1'b0);
            check1("valid", valid, m_valid);
            if (m_valid) check32("data", data, m_data);

            if (rst) begin
                p_low = 0; p_since = 0; p_seen = 1'b0;
            end else begin
                if (SCLK && CSB) check1("sclk_while_csb_high", 1'b1, 1'b0);
                if (!CSB) begin
                    if (SCLK && !p_sclk && !p_seen) begin
                        check1("tcss_setup", (p_low >= TCSS_P), 1'b1);
                        p_seen = 1'b1;
                    end
                    p_low++;
                    p_since = SCLK ? 0 : p_since + 1;
                end else begin
                    if (!p_csb && p_seen) check1("tcsh_hold", (p_since >= TCSH_P), 1'b1);
                    p_low = 0; p_since = 0; p_seen = 1'b0;
                end
            end
            p_sclk = SCLK;
            p_csb  = CSB;
        end
    end

    task automatic issue_start(input logic [NB-1:0] w, input logic [3:0] h, output int s);
        @(negedge clk);
        fuse  = w;
        TCKHP = h;
        start = 1'b1;
        s     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle with start low; lat=-1 on timeout.
    task automatic wait_done(input int s, input bit noisy, input int stray_at,
                             input int hchg_at, output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1) begin
                lat = cyc - s;
                break;
            end
            start = 1'b0;
            if (noisy) begin
                start = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
                if ($urandom_range(0, 7) == 0) TCKHP = 4'($urandom);
            end
            if (cyc - s == stray_at) start = 1'b1;
            if (cyc - s == hchg_at) TCKHP = 4'd8;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int s, s2, lat, ndone;
        logic [NB-1:0] w;
        logic [3:0]    h;

        rst = 1'b0; start = 1'b0; TCKHP = 4'd4; DOUT = 1'b0; fuse = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check1("rst_CSB", CSB, 1'b1);
        check1("rst_SCLK", SCLK, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_valid", valid, 1'b0);
        check32("rst_data", data, 32'h0);
        rst = 1'b0;

        // Default timing read.
        issue_start(32'hA5A5_1234, 4'd4, s);
        wait_done(s, 1'b0, -1, -1, lat);
        check32("s1_latency", 32'(lat), 32'd261);
        check32("s1_data", data, 32'hA5A5_1234);
        check1("s1_valid", valid, 1'b1);
        check32("s1_sclk_rises", 32'(fidx), 32'd32);

        // Zero high period behaves as one cycle.
        issue_start(32'h0000_0001, 4'd0, s);
        wait_done(s, 1'b0, -1, -1, lat);
        check32("s2_latency", 32'(lat), 32'd165);
        check32("s2_data", data, 32'h0000_0001);
        check32("s2_sclk_rises", 32'(fidx), 32'd32);

        // Stray start at +50 and TCKHP change at +60 must not disturb the read.
        issue_start(32'h3C3C_0F0F, 4'd4, s);
        wait_done(s, 1'b0, 50, 60, lat);
        check32("s3_latency", 32'(lat), 32'd261);
        check32("s3_data", data, 32'h3C3C_0F0F);
        ndone = 0;
        repeat (300) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check32("s3_extra_done", 32'(ndone), 32'd0);
        check1("s3_idle", busy, 1'b0);

        // Asynchronous reset in the middle of a read.
        issue_start(32'hDEAD_BEEF, 4'd4, s);
        while (cyc < s + 100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check1("ar_CSB", CSB, 1'b1);
        check1("ar_SCLK", SCLK, 1'b0);
        check1("ar_busy", busy, 1'b0);
        check1("ar_valid", valid, 1'b0);
        check32("ar_data", data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue_start(32'hFFFF_FFFF, 4'd4, s);
        wait_done(s, 1'b0, -1, -1, lat);
        check32("ar_latency", 32'(lat), 32'd261);
        check32("ar_data_after", data, 32'hFFFF_FFFF);

        // Back-to-back: start held through DONE (ignored) and the next IDLE cycle (accepted).
        issue_start(32'h1357_9BDF, 4'd4, s);
        wait_done(s, 1'b0, -1, -1, lat);
        check32("bb_first_data", data, 32'h1357_9BDF);
        start = 1'b1;
        fuse  = 32'h5A5A_EDCB;
        @(negedge clk);
        s2 = cyc;
        check1("bb_valid_hold", valid, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check1("bb_valid_drop", valid, 1'b0);
        wait_done(s2, 1'b0, -1, -1, lat);
        check32("bb_latency", 32'(lat), 32'd261);
        check32("bb_data", data, 32'h5A5A_EDCB);

        // Random words and high periods with stray starts and TCKHP churn.
        for (int k = 0; k < 6; k++) begin
            w = NB'($urandom);
            h = 4'($urandom_range(0, 15));
            issue_start(w, h, s);
            wait_done(s, 1'b1, -1, -1, lat);
            check32("rnd_latency", 32'(lat), 32'(read_len(eff_h(h))));
            check32("rnd_data", data, w);
            TCKHP = 4'd4;
            repeat (3) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
